// File: rtl/ws2812_pkg.sv
// Shared types and default timing for the WS2812 single-wire LED driver.
package ws2812_pkg;

  localparam int unsigned BITS_PER_LED = 24;

  localparam int unsigned DEF_T_BIT    = 13;
  localparam int unsigned DEF_T0H      = 4;
  localparam int unsigned DEF_T1H      = 8;
  localparam int unsigned DEF_T_LATCH  = 600;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    LATCH = 2'd2
  } state_t;

  // One LED colour in wire order: green first, MSB first.
  typedef struct packed {
    logic [7:0] g;
    logic [7:0] r;
    logic [7:0] b;
  } grb_t;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ws2812_bit_timer.sv
// Produces the pulse-width-coded waveform of one data bit over T_BIT cycles.
module ws2812_bit_timer
  import ws2812_pkg::*;
#(
  parameter int unsigned T_BIT = DEF_T_BIT,
  parameter int unsigned T0H   = DEF_T0H,
  parameter int unsigned T1H   = DEF_T1H
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic bit_val,
  output logic level,
  output logic bit_end_c
);

  localparam int unsigned CW = cnt_width(T_BIT);
  localparam logic [CW-1:0] LAST_CYC = CW'(T_BIT - 1);
  localparam logic [CW-1:0] HI0      = CW'(T0H);
  localparam logic [CW-1:0] HI1      = CW'(T1H);

  logic          active;
  logic          bit_q;
  logic [CW-1:0] cyc;
  logic [CW-1:0] cyc_nxt;

  assign bit_end_c = active && (cyc == LAST_CYC);
  assign cyc_nxt   = cyc + CW'(1);

  // level is registered from the upcoming cycle count so it lines up with cyc.
  always_ff @(posedge clk) begin
    if (reset) begin
      active <= 1'b0;
      bit_q  <= 1'b0;
      cyc    <= '0;
      level  <= 1'b0;
    end else if (start) begin
      active <= 1'b1;
      bit_q  <= bit_val;
      cyc    <= '0;
      level  <= 1'b1;  // cycle 0 is always high since T0H > 0
    end else if (bit_end_c) begin
      active <= 1'b0;
      cyc    <= '0;
      level  <= 1'b0;
    end else if (active) begin
      cyc    <= cyc_nxt;
      level  <= (cyc_nxt < (bit_q ? HI1 : HI0));
    end
  end

endmodule

// File: rtl/ws2812_driver.sv
// Serialises one GRB colour onto a WS2812 data line, then holds the line low to latch.
module ws2812_driver
  import ws2812_pkg::*;
#(
  parameter int unsigned T_BIT   = DEF_T_BIT,
  parameter int unsigned T0H     = DEF_T0H,
  parameter int unsigned T1H     = DEF_T1H,
  parameter int unsigned T_LATCH = DEF_T_LATCH
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] red,
  input  logic [7:0] green,
  input  logic [7:0] blue,
  input  logic       valid,
  output logic       ready,
  output logic       busy,
  output logic       frame_done,
  output logic       dout
);

  localparam int unsigned LW = cnt_width(T_LATCH);
  localparam logic [LW-1:0] LAST_LATCH = LW'(T_LATCH - 1);
  localparam logic [4:0]    LAST_BIT   = 5'(BITS_PER_LED - 1);

  if (!((T0H > 0) && (T0H < T1H) && (T1H < T_BIT) && (T_LATCH >= 1))) begin : g_bad_timing
    $error("ws2812_driver: illegal timing parameters");
  end

  state_t                  state;
  logic [BITS_PER_LED-1:0] shreg;
  logic [4:0]              bit_idx;
  logic [LW-1:0]           latch_cnt;
  logic [LW-1:0]           latch_nxt;
  grb_t                    load_c;
  logic                    accept_c;
  logic                    last_bit_c;
  logic                    start_c;
  logic                    bit_val_c;
  logic                    bit_end_c;

  assign load_c     = '{g: green, r: red, b: blue};
  assign accept_c   = (state == IDLE) && valid && ready;
  assign last_bit_c = (bit_idx == LAST_BIT);
  assign start_c    = accept_c || ((state == SEND) && bit_end_c && !last_bit_c);
  // On accept the first bit comes straight from the inputs; later bits are the next shreg bit.
  assign bit_val_c  = accept_c ? green[7] : shreg[BITS_PER_LED-2];
  assign latch_nxt  = latch_cnt + LW'(1);

  ws2812_bit_timer #(
    .T_BIT (T_BIT),
    .T0H   (T0H),
    .T1H   (T1H)
  ) u_bit_timer (
    .clk       (clk),
    .reset     (reset),
    .start     (start_c),
    .bit_val   (bit_val_c),
    .level     (dout),
    .bit_end_c (bit_end_c)
  );

  // Frame sequencing with registered handshake and status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_idx    <= '0;
      latch_cnt  <= '0;
      ready      <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept_c) begin
            state   <= SEND;
            shreg   <= load_c;
            bit_idx <= '0;
            ready   <= 1'b0;
            busy    <= 1'b1;
          end else begin
            ready   <= 1'b1;
          end
        end
        SEND: begin
          if (bit_end_c) begin
            if (last_bit_c) begin
              state      <= LATCH;
              latch_cnt  <= '0;
              frame_done <= (LAST_LATCH == '0);
            end else begin
              shreg   <= {shreg[BITS_PER_LED-2:0], 1'b0};
              bit_idx <= bit_idx + 5'd1;
            end
          end
        end
        LATCH: begin
          if (latch_cnt == LAST_LATCH) begin
            state      <= IDLE;
            ready      <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
          end else begin
            latch_cnt  <= latch_nxt;
            frame_done <= (latch_nxt == LAST_LATCH);
          end
        end
        default: begin
          state      <= IDLE;
          ready      <= 1'b0;
          busy       <= 1'b0;
          frame_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ws2812_driver.sv
// Scoreboard bench: expected pulse widths and frame timing are queued at issue and checked by a monitor.
module tb_ws2812_driver;
  import ws2812_pkg::*;

  localparam int TB = 13, T0 = 4, T1 = 8, TL = 600;
  localparam int SB = 4, S0 = 1, S1 = 2, SL = 3;
  localparam int NB = BITS_PER_LED;

  typedef struct {
    int width;
    int low_before;
  } bit_exp_t;

  logic       clk = 1'b0;
  logic       reset, valid, ready, busy, frame_done, dout;
  logic [7:0] red, green, blue;
  logic       reset_s, valid_s, ready_s, busy_s, frame_done_s, dout_s;
  logic [7:0] red_s, green_s, blue_s;

  int errors = 0;
  int checks = 0;
  bit_exp_t exp_q[$];
  int exp_fd[$];
  int mon_bif = 0;
  int last_w = 0;

  always #5 clk = ~clk;

  ws2812_driver dut (
    .clk(clk), .reset(reset), .red(red), .green(green), .blue(blue), .valid(valid),
    .ready(ready), .busy(busy), .frame_done(frame_done), .dout(dout)
  );

  ws2812_driver #(.T_BIT(SB), .T0H(S0), .T1H(S1), .T_LATCH(SL)) dut_s (
    .clk(clk), .reset(reset_s), .red(red_s), .green(green_s), .blue(blue_s), .valid(valid_s),
    .ready(ready_s), .busy(busy_s), .frame_done(frame_done_s), .dout(dout_s)
  );

  function automatic void chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endfunction

  // Reference model: each bit is a high pulse of T1H or T0H, the rest of the bit period low.
  task automatic push_frame(input logic [7:0] g, input logic [7:0] r, input logic [7:0] b,
                            input bit b2b);
    logic [23:0] v;
    bit_exp_t e;
    v = {g, r, b};
    for (int i = 0; i < NB; i++) begin
      e.width = v[23-i] ? T1 : T0;
      if (i == 0) e.low_before = b2b ? (TB - last_w) + TL + 1 : -1;
      else        e.low_before = TB - last_w;
      exp_q.push_back(e);
      last_w = e.width;
    end
    exp_fd.push_back(NB * TB + TL - 1);
  endtask

  // Monitor: measures every dout pulse and every frame_done and scores them against the queues.
  int cyc_n = 0, hi_run = 0, low_run = 0, low_saved = 0, frame_start = 0;
  logic prev_d = 1'b0;
  always @(negedge clk) begin : mon
    bit_exp_t e;
    cyc_n++;
    if (reset) begin
      hi_run = 0; low_run = 0; prev_d = 1'b0; mon_bif = 0;
    end else begin
      if (dout === 1'b1) begin
        if (!prev_d) begin
          low_saved = low_run;
          hi_run = 1;
          if (mon_bif == 0) frame_start = cyc_n;
        end else begin
          hi_run++;
        end
      end else begin
        if (prev_d) begin
          chk("pulse_expected", int'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk($sformatf("bit%0d_width", mon_bif), hi_run, e.width);
            if (e.low_before >= 0) chk($sformatf("bit%0d_low_before", mon_bif), low_saved, e.low_before);
          end
          mon_bif = (mon_bif == NB - 1) ? 0 : mon_bif + 1;
          low_run = 1;
        end else begin
          low_run++;
        end
      end
      if (frame_done === 1'b1) begin
        chk("frame_done_expected", int'(exp_fd.size() > 0), 1);
        if (exp_fd.size() > 0) chk("frame_done_offset", cyc_n - frame_start, exp_fd.pop_front());
      end
      prev_d = (dout === 1'b1);
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (ready !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", int'(ready === 1'b1), 1);
  endtask

  task automatic start_frame(input logic [7:0] g, input logic [7:0] r, input logic [7:0] b);
    wait_ready();
    green = g; red = r; blue = b; valid = 1'b1;
    push_frame(g, r, b, 1'b0);
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic run_small(input logic [7:0] g, input logic [7:0] r, input logic [7:0] b);
    int lvl[$];
    int n;
    logic [23:0] v;
    v = {g, r, b};
    for (int i = 0; i < NB; i++)
      for (int c = 0; c < SB; c++) lvl.push_back((c < (v[23-i] ? S1 : S0)) ? 1 : 0);
    for (int c = 0; c < SL; c++) lvl.push_back(0);
    n = 0;
    while (ready_s !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("small_ready_wait", int'(ready_s === 1'b1), 1);
    green_s = g; red_s = r; blue_s = b; valid_s = 1'b1;
    for (int i = 0; i < lvl.size(); i++) begin
      @(negedge clk);
      valid_s = 1'b0;
      chk($sformatf("small_dout_c%0d", i), int'(dout_s), lvl[i]);
      chk($sformatf("small_frame_done_c%0d", i), int'(frame_done_s), (i == lvl.size() - 1) ? 1 : 0);
    end
    @(negedge clk);
    chk("small_ready_after_frame", int'(ready_s), 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached with %0d errors", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1; valid = 1'b0; red = '0; green = '0; blue = '0;
    reset_s = 1'b1; valid_s = 1'b0; red_s = '0; green_s = '0; blue_s = '0;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset_dout", int'(dout), 0);
      chk("reset_busy", int'(busy), 0);
      chk("reset_frame_done", int'(frame_done), 0);
      chk("reset_ready", int'(ready), 0);
    end
    reset = 1'b0; reset_s = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", int'(ready), 1);
    chk("busy_after_reset", int'(busy), 0);

    // Directed colour from the single-frame case.
    start_frame(8'hFF, 8'h00, 8'h01);
    repeat (20) @(negedge clk);
    chk("busy_in_send", int'(busy), 1);
    chk("ready_in_send", int'(ready), 0);

    // Requests while busy must be ignored.
    start_frame(8'($urandom), 8'($urandom), 8'($urandom));
    repeat (30) @(negedge clk);
    valid = 1'b1; red = 8'hAA;
    repeat (5) @(negedge clk);
    valid = 1'b0;

    // Random colours, random idle gaps, inputs scrambled while in flight.
    for (int k = 0; k < 4; k++) begin
      wait_ready();
      repeat ($urandom_range(0, 3)) @(negedge clk);
      start_frame(8'($urandom), 8'($urandom), 8'($urandom));
      green = 8'($urandom); red = 8'($urandom); blue = 8'($urandom);
    end

    // Back-to-back frames with valid held high.
    wait_ready();
    green = '0; red = '0; blue = '0; valid = 1'b1;
    push_frame(8'h00, 8'h00, 8'h00, 1'b0);
    push_frame(8'h00, 8'h00, 8'h00, 1'b1);
    repeat (NB * TB + TL + 1 + 20) @(negedge clk);
    valid = 1'b0;

    // Reset in the middle of bit 10, then a fresh frame.
    start_frame(8'($urandom), 8'($urandom), 8'($urandom));
    n = 0;
    while (!(mon_bif == 10 && dout === 1'b1) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("reached_bit10", mon_bif, 10);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_dout", int'(dout), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_frame_done", int'(frame_done), 0);
    exp_q.delete();
    exp_fd.delete();
    @(negedge clk);
    reset = 1'b0;
    start_frame(8'($urandom), 8'($urandom), 8'($urandom));

    n = 0;
    while ((exp_q.size() > 0 || exp_fd.size() > 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("scoreboard_drained", exp_q.size() + exp_fd.size(), 0);
    repeat (50) @(negedge clk);
    chk("idle_at_end_busy", int'(busy), 0);
    chk("idle_at_end_ready", int'(ready), 1);

    // Reduced timing parameters.
    run_small(8'h80, 8'h00, 8'h00);
    run_small(8'($urandom), 8'($urandom), 8'($urandom));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
